lsu_data_mem: RTL

Byte-addressed, size-aware data memory for the RV32/RV64 load/store path, replacing the word-addressed, mask-driven data memory. It accepts one load or store per request over a valid/ready handshake, handles byte-lane steering, store masking and load sign/zero extension internally, and flags misaligned accesses. Read and write latency are both 1 + WAIT_STATES cycles, which lets the pipeline model slow memories.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_array.sv | 43 ++++
 rtl/lsu_data_mem.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the size-aware LSU data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Byte-enable pattern for an access of the given size starting at byte lane 'lane'.
    function automatic logic [7:0] byte_mask(size_e size, logic [2:0] lane);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0f;
            default: base = 8'hff;
        endcase
        return base << lane;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables, registered read port
// and asynchronous clear of every location.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DW          = 32,
    parameter int NO_OF_WORDS = 256,
    localparam int NBYTES     = DW / 8,
    localparam int IDXW       = $clog2(NO_OF_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              re_i,
    input  logic [NBYTES-1:0] be_i,
    input  logic [IDXW-1:0]   idx_i,
    input  logic [DW-1:0]     wdata_i,
    output logic [DW-1:0]     rdata_o
);

    logic [DW-1:0] mem_q [NO_OF_WORDS];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < NO_OF_WORDS; w++) begin
                mem_q[w] <= '0;
            end
            rdata_q <= '0;
        end else begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
            if (re_i) begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_data_mem.sv
// Byte-addressed load/store data memory: request FSM with optional wait states,
// lane steering, store masking, load extension and misalignment detection.
module lsu_data_mem
    import dmem_pkg::*;
#(
    parameter int DW             = 32,
    parameter int MEM_SIZE_IN_KB = 1,
    parameter int WAIT_STATES    = 0,
    localparam int NBYTES        = DW / 8,
    localparam int OFFW          = $clog2(NBYTES),
    localparam int ADDRW         = $clog2(MEM_SIZE_IN_KB * 1024),
    localparam int NO_OF_WORDS   = MEM_SIZE_IN_KB * 1024 / NBYTES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             ready_o,
    input  logic             we_i,
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    input  logic [ADDRW-1:0] addr_i,
    input  logic [DW-1:0]    wdata_i,
    output logic             rvalid_o,
    output logic [DW-1:0]    rdata_o,
    output logic             err_o
);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             we_q, we_d, uns_q, uns_d, err_q, err_d;
    size_e            size_q, size_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;

    logic             accept, req_err;
    logic             op_en, op_we;
    size_e            op_size;
    logic [ADDRW-1:0] op_addr;
    logic [DW-1:0]    op_wdata;
    logic [OFFW-1:0]  op_lane;
    logic [NBYTES-1:0] mem_be;
    logic [DW-1:0]    mem_wdata, mem_rdata, sh, ext;

    assign ready_o = (state_q != WAIT);
    assign accept  = req_i & ready_o;

    always_comb begin
        case (size_e'(size_i))
            SZ_B:    req_err = 1'b0;
            SZ_H:    req_err = addr_i[0];
            SZ_W:    req_err = |addr_i[1:0];
            default: req_err = (DW == 32) || (|addr_i[2:0]);
        endcase
    end

    // The memory operation fires on the edge that enters RESP: from the live
    // inputs on a zero-wait accept, otherwise from the latched request.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        op_en    = 1'b0;
        op_we    = we_q;
        op_size  = size_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;

        case (state_q)
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    op_en   = ~err_q;
                end
            end
            RESP:    state_d = IDLE;
            default: ;
        endcase

        if (accept) begin
            we_d    = we_i;
            size_d  = size_e'(size_i);
            uns_d   = unsigned_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            err_d   = req_err;
            cnt_d   = 4'(WAIT_STATES);
            if (!req_err && WAIT_STATES > 0) begin
                state_d = WAIT;
            end else begin
                state_d  = RESP;
                op_en    = ~req_err;
                op_we    = we_i;
                op_size  = size_e'(size_i);
                op_addr  = addr_i;
                op_wdata = wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign op_lane   = op_addr[OFFW-1:0];
    assign mem_be    = (op_en && op_we) ? NBYTES'(byte_mask(op_size, 3'(op_lane))) : '0;
    assign mem_wdata = op_wdata << {op_lane, 3'b000};

    dmem_array #(
        .DW          (DW),
        .NO_OF_WORDS (NO_OF_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .re_i    (op_en & ~op_we),
        .be_i    (mem_be),
        .idx_i   (op_addr[ADDRW-1:OFFW]),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        sh = mem_rdata >> {addr_q[OFFW-1:0], 3'b000};
        case (size_q)
            SZ_B:    ext = uns_q ? DW'(sh[7:0])  : DW'($signed(sh[7:0]));
            SZ_H:    ext = uns_q ? DW'(sh[15:0]) : DW'($signed(sh[15:0]));
            SZ_W:    ext = uns_q ? DW'(sh[31:0]) : DW'($signed(sh[31:0]));
            default: ext = sh;
        endcase
    end

    assign rvalid_o = (state_q == RESP);
    assign err_o    = rvalid_o & err_q;
    assign rdata_o  = (rvalid_o && !we_q && !err_q) ? ext : '0;

endmodule
